// File: rtl/led_matrix_column_scanner.sv
// Column scanner for the 5x7 LED matrix.
// Takes a Y-symmetric image as three 7-bit column vectors and drives the
// five physical columns one at a time. Each slot begins with a few dark
// cycles so the previous column does not ghost into the next one. The image
// is latched once per frame, so a frame always shows a single image.
//
// Handshake: there is no valid/ready pair. The col_* inputs are sampled only
// on the cycle a frame snapshot is taken, which is the cycle before
// frame_start is high. Every output is a register that is valid on every
// cycle after reset.
module led_matrix_column_scanner #(
   parameter int TICKS_PER_COLUMN = 5000,
   parameter int BLANK_TICKS      = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enable,
   input  logic [6:0] col_2,
   input  logic [6:0] col_1,
   input  logic [6:0] col_0,
   output logic [4:0] column_n,
   output logic [6:0] row_n,
   output logic [2:0] active_column,
   output logic       frame_start
);

   localparam int TW = $clog2(TICKS_PER_COLUMN);
   localparam logic [TW-1:0] TICK_LAST  = TW'(TICKS_PER_COLUMN - 1);
   localparam logic [TW-1:0] BLANK_LAST = (BLANK_TICKS > 0) ? TW'(BLANK_TICKS - 1) : '0;
   localparam logic [2:0]    LAST_COL   = 3'd4;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_BLANK = 2'd1,
      S_DRIVE = 2'd2
   } state_t;

   state_t          r_state;
   logic [TW-1:0]   r_tick;
   logic [2:0]      r_col;
   logic [20:0]     r_snap;      // {col_2, col_1, col_0}
   logic            r_fs;
   logic [4:0]      r_column_n;
   logic [6:0]      r_row_n;

   state_t          w_state_nx;
   state_t          w_slot_start;
   logic [TW-1:0]   w_tick_nx;
   logic [2:0]      w_col_nx;
   logic [20:0]     w_snap_nx;
   logic            w_fs_nx;
   logic [6:0]      w_sel;
   logic [4:0]      w_column_n_nx;
   logic [6:0]      w_row_n_nx;

   // Next-state logic. The outputs are computed from the next state, so they
   // are registered and line up with the state they describe.
   always_comb begin
      w_slot_start  = (BLANK_TICKS == 0) ? S_DRIVE : S_BLANK;
      w_state_nx    = r_state;
      w_tick_nx     = r_tick;
      w_col_nx      = r_col;
      w_snap_nx     = r_snap;
      w_fs_nx       = 1'b0;
      w_sel         = 7'd0;
      w_column_n_nx = 5'b11111;
      w_row_n_nx    = 7'b1111111;

      if (!enable) begin
         // Disable has priority over a wrap that happens on the same edge,
         // so no frame_start pulse is produced.
         w_state_nx = S_IDLE;
         w_tick_nx  = '0;
         w_col_nx   = 3'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               w_snap_nx  = {col_2, col_1, col_0};
               w_col_nx   = 3'd0;
               w_tick_nx  = '0;
               w_fs_nx    = 1'b1;
               w_state_nx = w_slot_start;
            end
            S_BLANK: begin
               w_tick_nx = r_tick + 1'b1;
               if (r_tick == BLANK_LAST) begin
                  w_state_nx = S_DRIVE;
               end
            end
            S_DRIVE: begin
               if (r_tick == TICK_LAST) begin
                  w_tick_nx  = '0;
                  w_state_nx = w_slot_start;
                  if (r_col == LAST_COL) begin
                     // End of frame: start over at column 0 with a new image.
                     w_col_nx  = 3'd0;
                     w_snap_nx = {col_2, col_1, col_0};
                     w_fs_nx   = 1'b1;
                  end else begin
                     w_col_nx = r_col + 3'd1;
                  end
               end else begin
                  w_tick_nx = r_tick + 1'b1;
               end
            end
            default: begin
               w_state_nx = S_IDLE;
               w_tick_nx  = '0;
               w_col_nx   = 3'd0;
            end
         endcase
      end

      // The image is Y-symmetric: outer columns share col_2, the next pair
      // shares col_1, and the centre column uses col_0.
      case (w_col_nx)
         3'd0, 3'd4: w_sel = w_snap_nx[20:14];
         3'd1, 3'd3: w_sel = w_snap_nx[13:7];
         default:    w_sel = w_snap_nx[6:0];
      endcase

      if (w_state_nx == S_DRIVE) begin
         w_column_n_nx = ~(5'b00001 << w_col_nx);
         w_row_n_nx    = ~w_sel;
      end
   end

   // State and output registers. Reset has priority over every other event.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_tick     <= '0;
         r_col      <= 3'd0;
         r_snap     <= '0;
         r_fs       <= 1'b0;
         r_column_n <= 5'b11111;
         r_row_n    <= 7'b1111111;
      end else begin
         r_state    <= w_state_nx;
         r_tick     <= w_tick_nx;
         r_col      <= w_col_nx;
         r_snap     <= w_snap_nx;
         r_fs       <= w_fs_nx;
         r_column_n <= w_column_n_nx;
         r_row_n    <= w_row_n_nx;
      end
   end

   assign column_n      = r_column_n;
   assign row_n         = r_row_n;
   assign active_column = r_col;
   assign frame_start   = r_fs;

endmodule

// File: tb/tb_led_matrix_column_scanner.sv
// Bench for led_matrix_column_scanner. It runs two configurations side by
// side: 4 ticks per column with 1 blank tick, and 2 ticks per column with no
// blank ticks. A frame-position model predicts every output cycle.
module tb_led_matrix_column_scanner;

   localparam int TA = 4;
   localparam int BA = 1;
   localparam int TB = 2;
   localparam int BB = 0;
   localparam int W  = 16;   // {column_n, row_n, active_column, frame_start}

   localparam logic [6:0] SPL_C2 = 7'b1001110;
   localparam logic [6:0] SPL_C1 = 7'b0111100;
   localparam logic [6:0] SPL_C0 = 7'b0000000;
   localparam logic [6:0] DRP_C2 = 7'b0110001;
   localparam logic [6:0] DRP_C1 = 7'b1100000;
   localparam logic [6:0] DRP_C0 = 7'b1000000;

   // Clock and reset.
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       a_rst_n, a_en;
   logic [6:0] a_c2, a_c1, a_c0;
   logic [4:0] a_column_n;
   logic [6:0] a_row_n;
   logic [2:0] a_active_column;
   logic       a_frame_start;

   logic       b_rst_n, b_en;
   logic [6:0] b_c2, b_c1, b_c0;
   logic [4:0] b_column_n;
   logic [6:0] b_row_n;
   logic [2:0] b_active_column;
   logic       b_frame_start;

   led_matrix_column_scanner #(.TICKS_PER_COLUMN(TA), .BLANK_TICKS(BA)) dut_a (
      .clk           (clk),
      .rst_n         (a_rst_n),
      .enable        (a_en),
      .col_2         (a_c2),
      .col_1         (a_c1),
      .col_0         (a_c0),
      .column_n      (a_column_n),
      .row_n         (a_row_n),
      .active_column (a_active_column),
      .frame_start   (a_frame_start)
   );

   led_matrix_column_scanner #(.TICKS_PER_COLUMN(TB), .BLANK_TICKS(BB)) dut_b (
      .clk           (clk),
      .rst_n         (b_rst_n),
      .enable        (b_en),
      .col_2         (b_c2),
      .col_1         (b_c1),
      .col_0         (b_c0),
      .column_n      (b_column_n),
      .row_n         (b_row_n),
      .active_column (b_active_column),
      .frame_start   (b_frame_start)
   );

   // Scoreboard.
   logic [W-1:0] exp_a_q[$];
   logic [W-1:0] exp_b_q[$];
   int checks = 0;
   int errors = 0;

   // Reference model: the position inside the current frame, counted in
   // cycles since the snapshot, together with the snapshot itself.
   bit          m_run[2];
   int          m_pos[2];
   logic [20:0] m_snap[2];

   function automatic logic [6:0] pick(input logic [20:0] s, input int slot);
      if (slot == 0 || slot == 4) return s[20:14];
      if (slot == 1 || slot == 3) return s[13:7];
      return s[6:0];
   endfunction

   function automatic logic [W-1:0] step(input int k, input int t, input int b,
                                         input logic rst_n, input logic en,
                                         input logic [6:0] c2, input logic [6:0] c1,
                                         input logic [6:0] c0);
      logic       fs;
      logic [4:0] cn;
      logic [6:0] rn;
      logic [2:0] ac;
      int         slot;
      int         off;
      fs = 1'b0;
      cn = 5'b11111;
      rn = 7'b1111111;
      ac = 3'd0;
      if (!rst_n) begin
         m_run[k]  = 1'b0;
         m_pos[k]  = 0;
         m_snap[k] = '0;
      end else if (!en) begin
         m_run[k] = 1'b0;
         m_pos[k] = 0;
      end else if (!m_run[k]) begin
         m_run[k]  = 1'b1;
         m_pos[k]  = 0;
         m_snap[k] = {c2, c1, c0};
         fs        = 1'b1;
      end else begin
         m_pos[k] = m_pos[k] + 1;
         if (m_pos[k] == 5 * t) begin
            m_pos[k]  = 0;
            m_snap[k] = {c2, c1, c0};
            fs        = 1'b1;
         end
      end
      if (m_run[k]) begin
         slot = m_pos[k] / t;
         off  = m_pos[k] % t;
         ac   = 3'(slot);
         if (off >= b) begin
            cn       = 5'b11111;
            cn[slot] = 1'b0;
            rn       = ~pick(m_snap[k], slot);
         end
      end
      return {cn, rn, ac, fs};
   endfunction

   // Driver tasks: predict the outputs for the inputs sampled at this edge,
   // then apply the next control values just after the edge.
   task automatic cycle_a(input logic r, input logic e);
      @(posedge clk);
      exp_a_q.push_back(step(0, TA, BA, a_rst_n, a_en, a_c2, a_c1, a_c0));
      #1;
      a_rst_n = r;
      a_en    = e;
   endtask

   task automatic cycle_b(input logic r, input logic e);
      @(posedge clk);
      exp_b_q.push_back(step(1, TB, BB, b_rst_n, b_en, b_c2, b_c1, b_c0));
      #1;
      b_rst_n = r;
      b_en    = e;
   endtask

   task automatic run_until_a(input int slot, input bit need_drive);
      int n;
      n = 0;
      while (!(m_run[0] && (m_pos[0] / TA == slot) &&
               (!need_drive || (m_pos[0] % TA >= BA))) && n < 100) begin
         cycle_a(1'b1, 1'b1);
         n++;
      end
      if (n >= 100) begin
         errors++;
         $display("FAIL run_until_a timeout: slot %0d not reached after %0d cycles, required within 100",
                  slot, n);
      end
   endtask

   task automatic run_a();
      for (int i = 0; i < 3; i++) begin
         a_c2 = 7'($urandom); a_c1 = 7'($urandom); a_c0 = 7'($urandom);
         cycle_a(1'b0, 1'b1);
      end
      cycle_a(1'b1, 1'b1);
      a_c2 = SPL_C2; a_c1 = SPL_C1; a_c0 = SPL_C0;
      repeat (25) cycle_a(1'b1, 1'b1);
      // Change the image mid-frame; it must only appear at the next wrap.
      run_until_a(2, 1'b0);
      a_c2 = DRP_C2; a_c1 = DRP_C1; a_c0 = DRP_C0;
      repeat (30) cycle_a(1'b1, 1'b1);
      // Drop enable while column 3 is driven, then re-raise it.
      run_until_a(3, 1'b1);
      a_en = 1'b0;
      repeat (4) cycle_a(1'b1, 1'b0);
      cycle_a(1'b1, 1'b1);
      repeat (25) cycle_a(1'b1, 1'b1);
      // Reset while column 1 is driven.
      run_until_a(1, 1'b1);
      a_rst_n = 1'b0;
      cycle_a(1'b1, 1'b1);
      repeat (25) cycle_a(1'b1, 1'b1);
      for (int i = 0; i < 500; i++) begin
         cycle_a(logic'($urandom_range(0, 59) != 0), logic'($urandom_range(0, 24) != 0));
         if ($urandom_range(0, 7) == 0) begin
            a_c2 = 7'($urandom); a_c1 = 7'($urandom); a_c0 = 7'($urandom);
         end
      end
   endtask

   task automatic run_b();
      for (int i = 0; i < 2; i++) begin
         b_c2 = 7'($urandom); b_c1 = 7'($urandom); b_c0 = 7'($urandom);
         cycle_b(1'b0, 1'b1);
      end
      cycle_b(1'b1, 1'b1);
      b_c2 = SPL_C2; b_c1 = SPL_C1; b_c0 = SPL_C0;
      repeat (25) cycle_b(1'b1, 1'b1);
      for (int i = 0; i < 400; i++) begin
         cycle_b(logic'($urandom_range(0, 59) != 0), logic'($urandom_range(0, 19) != 0));
         if ($urandom_range(0, 5) == 0) begin
            b_c2 = 7'($urandom); b_c1 = 7'($urandom); b_c0 = 7'($urandom);
         end
      end
   endtask

   // Monitors: compare each cycle's outputs against the queued prediction.
   initial begin
      logic [W-1:0] got;
      logic [W-1:0] exp;
      forever begin
         @(negedge clk);
         if (exp_a_q.size() > 0) begin
            exp = exp_a_q.pop_front();
            got = {a_column_n, a_row_n, a_active_column, a_frame_start};
            checks++;
            if (got !== exp) begin
               errors++;
               $display("FAIL dut_a outputs @%0t: got col_n=%b row_n=%b col=%0d fs=%b, expected col_n=%b row_n=%b col=%0d fs=%b",
                        $time, got[15:11], got[10:4], got[3:1], got[0],
                        exp[15:11], exp[10:4], exp[3:1], exp[0]);
            end
            checks++;
            if ($countones(~a_column_n) > 1) begin
               errors++;
               $display("FAIL dut_a one_hot @%0t: column_n=%b, required at most one low bit",
                        $time, a_column_n);
            end
         end
      end
   end

   initial begin
      logic [W-1:0] got;
      logic [W-1:0] exp;
      forever begin
         @(negedge clk);
         if (exp_b_q.size() > 0) begin
            exp = exp_b_q.pop_front();
            got = {b_column_n, b_row_n, b_active_column, b_frame_start};
            checks++;
            if (got !== exp) begin
               errors++;
               $display("FAIL dut_b outputs @%0t: got col_n=%b row_n=%b col=%0d fs=%b, expected col_n=%b row_n=%b col=%0d fs=%b",
                        $time, got[15:11], got[10:4], got[3:1], got[0],
                        exp[15:11], exp[10:4], exp[3:1], exp[0]);
            end
            checks++;
            if ($countones(~b_column_n) > 1) begin
               errors++;
               $display("FAIL dut_b one_hot @%0t: column_n=%b, required at most one low bit",
                        $time, b_column_n);
            end
         end
      end
   end

   // Main sequence and final report.
   initial begin
      m_run[0] = 1'b0; m_run[1] = 1'b0;
      m_pos[0] = 0;    m_pos[1] = 0;
      m_snap[0] = '0;  m_snap[1] = '0;
      a_rst_n = 1'b0; a_en = 1'b1;
      a_c2 = 7'($urandom); a_c1 = 7'($urandom); a_c0 = 7'($urandom);
      b_rst_n = 1'b0; b_en = 1'b1;
      b_c2 = 7'($urandom); b_c1 = 7'($urandom); b_c0 = 7'($urandom);
      fork
         run_a();
         run_b();
      join
      @(negedge clk);
      #1;
      if (exp_a_q.size() != 0 || exp_b_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d/%0d predictions left unchecked, required 0/0",
                  exp_a_q.size(), exp_b_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/led_matrix_column_scanner.md
Name: led_matrix_column_scanner

Overview:
- Time-multiplexed driver for the CPLD kit's 5x7 LED matrix.
- Sits directly downstream of the image decoders, which deliver Y-symmetric images as three 7-bit column vectors: col_2 drives physical columns 0 and 4, col_1 drives columns 1 and 3, col_0 drives column 2.
- Scans the five physical columns one at a time, inserts a blanking gap at each column change to stop ghosting, and latches the image once per frame so the display never tears.

Parameters:
- TICKS_PER_COLUMN, 5000: clk cycles per column slot. Must be >= 2.
- BLANK_TICKS, 2: cycles at the start of each slot with all LEDs off. Must satisfy 0 <= BLANK_TICKS < TICKS_PER_COLUMN.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset; synchronous, active-low
- enable  input  1  1 = scan, 0 = display dark
- col_2  input  7  image data for physical columns 0 and 4 (bit 6 = top row)
- col_1  input  7  image data for physical columns 1 and 3
- col_0  input  7  image data for physical column 2
- column_n  output  5  column enables, one-hot active-low (bit k = physical column k)
- row_n  output  7  row drive, active-low (row_n = ~image bits of the active column)
- active_column  output  3  index 0..4 of the current slot
- frame_start  output  1  one-cycle pulse when a new frame snapshot is latched

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- All outputs are registered.
- Reset (rst_n=0 at a clk edge) values:
  - column_n = 5'b11111, row_n = 7'b1111111.
  - active_column = 0, frame_start = 0.
  - tick counter = 0, snapshot = 0, state = IDLE.
  - Reset takes priority over every other event, including mid-slot.
- States:
  - IDLE: outputs dark.
    - enable=1 → latch snapshot {col_2, col_1, col_0}; active_column = 0; tick = 0; frame_start = 1 for one cycle.
    - Next state is BLANK, or DRIVE if BLANK_TICKS = 0.
  - BLANK: column_n = 11111, row_n = 1111111; tick increments each cycle.
    - When tick = BLANK_TICKS-1 → DRIVE.
  - DRIVE: column_n has only bit active_column low; row_n = ~snapshot column selected by the mapping.
    - Mapping: index 0/4 → col_2, 1/3 → col_1, 2 → col_0.
    - When tick = TICKS_PER_COLUMN-1 → tick = 0 and active_column advances.
    - If active_column = 4: wrap to 0, re-latch snapshot from the inputs on that same edge, pulse frame_start.
    - Next state is BLANK, or DRIVE if BLANK_TICKS = 0.
- Tick counter width is clog2(TICKS_PER_COLUMN). Tick is never compared beyond TICKS_PER_COLUMN-1.
- Every slot is exactly TICKS_PER_COLUMN cycles: BLANK_TICKS dark cycles, then the driven cycles. Frame period is 5*TICKS_PER_COLUMN.
- Input changes mid-frame are ignored until the next wrap. The snapshot is the only path from the inputs to the outputs.
- enable=0 in any state: on the next edge go to IDLE with dark outputs, active_column = 0, tick = 0, frame_start = 0.
- enable and the wrap condition in the same cycle: enable=0 wins, with no frame_start pulse.
- Outputs become valid one cycle after the state transition that causes them; frame_start coincides with the first cycle of column 0's slot.
- Exactly one column_n bit is low at any time, or none. Two low bits is an error.

Test Plan (TICKS_PER_COLUMN=4, BLANK_TICKS=1):
- Reset: hold rst_n=0 for 3 cycles with enable=1 and random cols → column_n=11111, row_n=1111111, active_column=0, frame_start=0 throughout.
- Splinker image (col_2=1001110, col_1=0111100, col_0=0000000), enable rises → frame_start pulses once; the expected per-slot sequence is:
  - Column 0: 1 dark cycle, then 3 cycles of column_n=11110, row_n=0110001.
  - Column 1: row_n=1000011.
  - Column 2: row_n=1111111.
  - Column 3: row_n=1000011.
  - Column 4: row_n=0110001.
  - Then frame_start again exactly 20 cycles after the first pulse.
- Tear-free latching: switch the inputs to the dripper image (col_2=0110001, col_1=1100000, col_0=1000000) during column 2 → columns 2-4 still show the splinker image; column 0 of the next frame shows row_n=1001110.
- Enable drop mid-DRIVE in column 3 → next cycle column_n=11111, active_column=0, no frame_start. Re-raising enable restarts at column 0 with a frame_start pulse.
- Reset mid-operation in column 1 DRIVE → next cycle all reset values. After release with enable=1, a new frame starts at column 0.
- BLANK_TICKS=0, TICKS_PER_COLUMN=2 → no dark cycles, each column driven for 2 cycles, period 10. Assert across all tests: at most one column_n bit is low.
